pc_redirect: RTL
================

Name: pc_redirect

Overview:
Program-counter and fetch-request stage that sits directly downstream of the jump unit (ju). It consumes the jump unit's pc control code, branch offset and jump target. It holds the architectural fetch PC, drives a req/ack fetch handshake to instruction memory, and applies sequential, jump and branch redirects without disturbing an outstanding request. It also flags wrong-path fetches and misaligned targets.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
pc_c  input  2  redirect code from jump unit: 0 none, 1 jump, 2 branch taken, 3 treated as 0
im_in  input  13  branch byte offset, two's complement, valid when pc_c==2
br_base  input  32  PC of the branch/jump instruction being resolved
tgt_in  input  32  jump target, valid when pc_c==1
stall  input  1  downstream back-pressure; no new fetch issued while high
if_ack  input  1  instruction memory accepts the current request this cycle
if_req  output  1  fetch request valid
if_addr  output  32  fetch address; stable while if_req=1 and if_ack=0
fetch_valid  output  1  registered; instruction acked last cycle is on the correct path
fetch_pc  output  32  registered; address of the instruction flagged by fetch_valid
flush  output  1  registered one-cycle pulse after any redirect is accepted
misalign  output  1  registered one-cycle pulse when the accepted target has target[1]=1

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_ADDR, state <= IDLE.
  - if_req, fetch_valid, flush and misalign all <= 0; fetch_pc <= 0.
  - Pending-redirect valid (pend_v) <= 0.
  - Reset mid-request abandons the request; an if_ack arriving during reset is ignored.
- Target computation (combinational):
  - Branch: br_base + sign_ext32(im_in), modulo 2^32.
  - Jump: tgt_in with bit0 forced to 0.
  - Sequential: pc + PC_STEP, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- A redirect is "present" when pc_c is 1 or 2.
- State machine (if_req = 1 only in REQ; if_addr = pc):
  - IDLE: entered only from reset. Moves to REQ on the next cycle; any redirect present in IDLE is applied to pc.
  - REQ, if_ack=0: pc is held. A present redirect is latched into pend_tgt with pend_v <= 1; a later redirect overwrites the pending one.
  - REQ, if_ack=1: pc <= present redirect target, else pend_tgt if pend_v, else pc + PC_STEP. pend_v <= 0. Next state is HOLD if stall=1, otherwise REQ.
  - HOLD: if_req=0. A present redirect is applied to pc directly. Go to REQ when stall=0. A pending target is never left in HOLD.
- fetch_valid:
  - Set to 1 the cycle after if_ack only if, in the ack cycle, no redirect was present and pend_v=0. Otherwise 0, marking a wrong-path fetch.
  - fetch_pc <= if_addr on every ack.
- flush: 1 the cycle after a redirect is present in any non-reset state, whether it is latched or applied.
- misalign: 1 the cycle after an accepted redirect whose target[1]=1. The target is still loaded into pc.
- stall while in REQ does not withdraw if_req; it only selects HOLD after the ack.
- Latency: a redirect in HOLD or IDLE appears on if_addr in the next REQ cycle. In REQ it appears on the first request after the ack.

Test Plan:
- Reset with RESET_ADDR=0x100, stall=0, if_ack always 1 -> if_addr 0x100, 0x104, 0x108 on consecutive REQ cycles; fetch_valid=1 each cycle after the first ack.
- Branch: pc_c=2, br_base=0x200, im_in=13'h1FF8 (-8) while REQ with if_ack=0; ack two cycles later -> if_addr held at the old pc until the ack, next request at 0x1F8; flush pulses once; the acked instruction has fetch_valid=0.
- Jump: pc_c=1, tgt_in=0x0000_3003 in HOLD -> pc becomes 0x3002; misalign=1 and flush=1 for one cycle; first request after stall drops uses if_addr=0x3002.
- Wrap: pc=0xFFFF_FFFC, acked with no redirect -> next if_addr=0x0000_0000.
- Two redirects: pc_c=2 (target 0x400) then pc_c=1 (tgt_in 0x800) on successive non-ack REQ cycles -> after the ack, if_addr=0x800; flush high for two cycles.
- Reset mid-request with if_ack=1 on the reset cycle -> if_req=0, fetch_valid=0, pc=RESET_ADDR, no pending redirect survives.

Source files
------------

// File: rtl/pc_redirect.sv
// Fetch PC and request stage behind the jump unit: holds the fetch PC, runs the req/ack
// handshake and applies jump/branch redirects, deferring them while a request is in flight.
module pc_redirect #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_c,
    input  logic [12:0] im_in,
    input  logic [31:0] br_base,
    input  logic [31:0] tgt_in,
    input  logic        stall,
    input  logic        if_ack,
    output logic        if_req,
    output logic [31:0] if_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        flush,
    output logic        misalign
);
    // state | meaning
    // IDLE  | first cycle after reset, no request yet
    // REQ   | request outstanding on if_addr, waiting for if_ack
    // HOLD  | acked under stall, no request until stall drops
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_tgt;
    logic        pend_v;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] seq_pc;

    always_comb begin
        redir     = (pc_c == 2'd1) || (pc_c == 2'd2);
        redir_tgt = (pc_c == 2'd1) ? {tgt_in[31:1], 1'b0}
                                   : br_base + {{19{im_in[12]}}, im_in};
        seq_pc    = pc + STEP;
    end

    assign if_req  = (state == REQ);
    assign if_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            pend_tgt    <= 32'h0;
            pend_v      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_pc    <= 32'h0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            flush       <= redir;
            misalign    <= redir && redir_tgt[1];
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (redir) pc <= redir_tgt;
                    state <= REQ;
                end
                REQ: begin
                    if (if_ack) begin
                        if (redir)       pc <= redir_tgt;
                        else if (pend_v) pc <= pend_tgt;
                        else             pc <= seq_pc;
                        pend_v      <= 1'b0;
                        fetch_pc    <= pc;
                        // a redirect seen now or earlier means the acked fetch is wrong-path
                        fetch_valid <= !redir && !pend_v;
                        state       <= stall ? HOLD : REQ;
                    end else if (redir) begin
                        pend_tgt <= redir_tgt;
                        pend_v   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir) pc <= redir_tgt;
                    if (!stall) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
